// File: rtl/gpc_pipe_acc.sv
// Pipelined generalized parallel counter: popcount(src_lo) + popcount(src_hi) << SHIFT,
// with per-beat pass or frame-accumulate mode. Optional saturation: GPC_PIPE_ACC_SAT_EN.
module gpc_pipe_acc #(
  parameter int N_LO  = 7,
  parameter int N_HI  = 6,
  parameter int SHIFT = 2,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_LO-1:0]  src_lo,
  input  logic [N_HI-1:0]  src_hi,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int SW = $clog2(N_LO + N_HI * (2 ** SHIFT) + 1);
  localparam int LW = $clog2(N_LO + 1);
  localparam int HW = $clog2(N_HI + 1);

  generate
    if (ACC_W < SW) begin : g_width_chk
      $error("gpc_pipe_acc: ACC_W must be at least %0d", SW);
    end
  endgenerate

  logic             s1_valid;
  logic             s1_mode;
  logic             s1_last;
  logic [LW-1:0]    s1_pc_lo;
  logic [HW-1:0]    s1_pc_hi;
  logic             s2_valid;
  logic [ACC_W-1:0] s2_sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [SW-1:0]    sum;
  logic             s2_free;
  logic             move;

  assign s2_free  = !s2_valid || out_ready;
  assign move     = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;

  assign out_valid = s2_valid;
  assign out_sum   = s2_sum;

  always_comb begin
    sum = SW'(s1_pc_lo) + (SW'(s1_pc_hi) << SHIFT);
  end

`ifdef GPC_PIPE_ACC_SAT_EN
  logic [ACC_W:0] acc_ext;
  logic           sat_hit;
  logic           ovf_flag;
  logic           s2_ovf;

  always_comb begin
    acc_ext  = {1'b0, acc} + (ACC_W + 1)'(sum);
    sat_hit  = acc_ext[ACC_W];
    acc_next = sat_hit ? {ACC_W{1'b1}} : acc_ext[ACC_W-1:0];
  end

  // overflow is sticky across the frame and reported only on its closing beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (move) begin
      if (!s1_mode) begin
        s2_ovf <= 1'b0;
      end else if (s1_last) begin
        s2_ovf   <= ovf_flag || sat_hit;
        ovf_flag <= 1'b0;
      end else begin
        ovf_flag <= ovf_flag || sat_hit;
      end
    end
  end

  assign out_ovf = s2_ovf;
`else
  always_comb begin
    acc_next = acc + ACC_W'(sum);
  end

  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s1_pc_lo <= '0;
      s1_pc_hi <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      acc      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_pc_lo <= LW'($countones(src_lo));
          s1_pc_hi <= HW'($countones(src_hi));
          s1_mode  <= mode;
          s1_last  <= in_last;
        end
      end
      // mid-frame accumulate beats are absorbed and leave S2 empty
      if (s2_free) begin
        s2_valid <= move && (!s1_mode || s1_last);
      end
      if (move) begin
        if (!s1_mode) begin
          s2_sum <= ACC_W'(sum);
        end else if (s1_last) begin
          s2_sum <= acc_next;
          acc    <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpc_pipe_acc.sv
// Self-checking bench for gpc_pipe_acc: queue-based reference model plus directed literals.
module tb_gpc_pipe_acc;

  localparam int N_LO  = 7;
  localparam int N_HI  = 6;
  localparam int SHIFT = 2;
  localparam int ACC_W = 16;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N_LO-1:0]  src_lo;
  logic [N_HI-1:0]  src_hi;
  logic             mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  logic             in_valid6;
  logic             in_ready6;
  logic [N_LO-1:0]  src_lo6;
  logic [N_HI-1:0]  src_hi6;
  logic             mode6;
  logic             last6;
  logic             out_valid6;
  logic             out_ready6;
  logic [5:0]       out_sum6;
  logic             out_ovf6;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc = 0;
  bit   m_ovf = 1'b0;

  always #5 clk = ~clk;

  gpc_pipe_acc #(.N_LO(N_LO), .N_HI(N_HI), .SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_lo(src_lo), .src_hi(src_hi), .mode(mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  gpc_pipe_acc #(.N_LO(N_LO), .N_HI(N_HI), .SHIFT(SHIFT), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .src_lo(src_lo6), .src_hi(src_hi6), .mode(mode6), .in_last(last6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_sum(out_sum6), .out_ovf(out_ovf6)
  );

  // Reference: each accepted beat is a weighted popcount; frames sum them.
  function automatic void model_accept(input logic [N_LO-1:0] lo, input logic [N_HI-1:0] hi,
                                       input logic m, input logic l);
    int   s;
    int   t;
    bit   o;
    exp_t e;
    s = $countones(lo) + $countones(hi) * (1 << SHIFT);
    if (!m) begin
      e.sum = s;
      e.ovf = 1'b0;
      exp_q.push_back(e);
    end else begin
      t = m_acc + s;
      o = m_ovf;
      if (t > MAXV) begin
`ifdef GPC_PIPE_ACC_SAT_EN
        t = MAXV;
        o = 1'b1;
`else
        t = t % (MAXV + 1);
`endif
      end
      if (l) begin
        e.sum = t;
        e.ovf = o;
        exp_q.push_back(e);
        m_acc = 0;
        m_ovf = 1'b0;
      end else begin
        m_acc = t;
        m_ovf = o;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_unexpected: got out_sum=%0d with no beat expected", out_sum);
        end else begin
          if (int'(out_sum) != exp_q[0].sum || out_ovf !== exp_q[0].ovf) begin
            fails++;
            $display("FAIL stream_order: got sum=%0d ovf=%0b, expected sum=%0d ovf=%0b",
                     out_sum, out_ovf, exp_q[0].sum, exp_q[0].ovf);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept(src_lo, src_hi, mode, in_last);
    end
  end

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [N_LO-1:0] lo, input logic [N_HI-1:0] hi,
                      input logic m, input logic l, output int waits);
    logic ok;
    in_valid = 1'b1;
    src_lo   = lo;
    src_hi   = hi;
    mode     = m;
    in_last  = l;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout", waits, 0);
        break;
      end
    end
  endtask

  task automatic wait_out(output int s, output int o);
    s = -1;
    o = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        s = int'(out_sum);
        o = int'(out_ovf);
        break;
      end
    end
    if (s < 0) check("wait_out_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        check("drain_timeout", exp_q.size(), 0);
        break;
      end
    end
  endtask

  initial begin
    int w;
    int s;
    int o;
    int acc_cnt;
    int bad_ready;
    logic ok;
    logic [N_LO-1:0] bp_lo [4];
    logic [N_HI-1:0] bp_hi [4];

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    src_lo     = '0;
    src_hi     = '0;
    mode       = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    in_valid6  = 1'b0;
    src_lo6    = '0;
    src_hi6    = '0;
    mode6      = 1'b0;
    last6      = 1'b0;
    out_ready6 = 1'b1;

    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pass beat latency and value: popcount 2 + 4*4 = 18
    send(7'h30, 6'h2b, 1'b0, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("pass_lat_early", int'(out_valid), 0);
    @(negedge clk);
    check("pass_lat_valid", int'(out_valid), 1);
    check("pass_18", int'(out_sum), 18);
    @(posedge clk);
    #1;

    send('1, '1, 1'b0, 1'b0, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("pass_ones", s, 31);
    send('0, '0, 1'b0, 1'b0, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("pass_zeros", s, 0);
    check("pass_ovf", o, 0);

    // streaming
    bad_ready = 0;
    for (int i = 0; i < 20; i++) begin
      send(N_LO'($urandom), N_HI'($urandom), 1'b0, 1'b0, w);
      bad_ready += w;
    end
    in_valid = 1'b0;
    check("stream_in_ready_stalls", bad_ready, 0);
    drain();

    // backpressure: four beats offered while downstream is blocked
    bp_lo[0] = 7'h01; bp_hi[0] = 6'h00;
    bp_lo[1] = 7'h03; bp_hi[1] = 6'h01;
    bp_lo[2] = 7'h7f; bp_hi[2] = 6'h03;
    bp_lo[3] = 7'h00; bp_hi[3] = 6'h3f;
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      src_lo   = bp_lo[acc_cnt];
      src_hi   = bp_hi[acc_cnt];
      mode     = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) acc_cnt++;
    end
    check("bp_accepted", acc_cnt, 2);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_held_sum", int'(out_sum), 1);
    out_ready = 1'b1;
    for (int i = acc_cnt; i < 4; i++) send(bp_lo[i], bp_hi[i], 1'b0, 1'b0, w);
    in_valid = 1'b0;
    drain();

    // accumulate frame of three all-ones beats
    send('1, '1, 1'b1, 1'b0, w);
    send('1, '1, 1'b1, 1'b0, w);
    send('1, '1, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("acc_93", s, 93);
    check("acc_93_ovf", o, 0);
    send(7'h01, '0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("acc_next_frame", s, 1);

    // pass beat inside an open frame
    send(7'h07, '0, 1'b1, 1'b0, w);
    send(7'h01, 6'h01, 1'b0, 1'b1, w);
    send(7'h03, '0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("mixed_pass", s, 5);
    wait_out(s, o);
    check("mixed_frame", s, 5);

    // narrow accumulator
    for (int i = 0; i < 3; i++) begin
      in_valid6 = 1'b1;
      src_lo6   = '1;
      src_hi6   = '1;
      mode6     = 1'b1;
      last6     = (i == 2);
      @(posedge clk);
      #1;
    end
    in_valid6 = 1'b0;
    s = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid6) begin
        s = int'(out_sum6);
        o = int'(out_ovf6);
        break;
      end
    end
`ifdef GPC_PIPE_ACC_SAT_EN
    check("w6_sum", s, 63);
    check("w6_ovf", o, 1);
`else
    check("w6_sum", s, 29);
    check("w6_ovf", o, 0);
`endif
    @(posedge clk);
    #1;

    // reset mid-frame
    send('1, '1, 1'b1, 1'b0, w);
    send('1, '1, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(7'h01, '0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_out(s, o);
    check("midrst_frame", s, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
